// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the LEGv8 execute-stage hazard controller.
package ex_pkg;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam int ZERO_REG = 31;
endpackage

// File: rtl/ex_fwd_select.sv
// ex_fwd_select: operand-mux select for one source register; the EX/MEM producer beats MEM/WB.
module ex_fwd_select import ex_pkg::*; #(
  parameter int REG_AW = 5,
  parameter logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG)
) (
  input  logic              en_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              ex_valid_i,
  input  logic              ex_reg_write_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_valid_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  output logic [1:0]        sel_o
);
  logic ex_hit, mem_hit;
  always_comb begin
    ex_hit  = ex_valid_i & ex_reg_write_i & (ex_rd_i != ZR) & (ex_rd_i == src_i);
    mem_hit = mem_valid_i & mem_reg_write_i & (mem_rd_i != ZR) & (mem_rd_i == src_i);
    sel_o   = !en_i ? FWD_REG : ex_hit ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_REG;
  end
endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: ID/EX control register, forwarding selects, load-use stall and branch flush.
module ex_hazard_ctrl import ex_pkg::*; #(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = ex_pkg::ZERO_REG,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic [1:0]        id_alu_op,
  input  logic              id_cbz,
  input  logic              id_uncond,
  input  logic              ex_zero,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic              ex_valid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              pc_src,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);
  logic              ex_valid_q, ex_alu_src_q, ex_reg_write_q, ex_mem_read_q, ex_mem_write_q;
  logic              ex_cbz_q, ex_uncond_q;
  logic [1:0]        ex_alu_op_q, fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic              mem_valid_q, mem_reg_write_q, mem_mem_read_q;
  logic              wb_valid_q, wb_reg_write_q;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q, stall_cnt_d, flush_cnt_d;
  logic              taken, load_use, bubble;
  logic              unused_obs;
  always_comb begin
    taken       = ex_valid_q & (ex_uncond_q | (ex_cbz_q & ex_zero));
    load_use    = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != ZR) &
                  ((id_rn == ex_rd_q) | (id_uses_rm & (id_rm == ex_rd_q)));
    bubble      = ~id_valid | taken | load_use;
    stall_cnt_d = stall_cnt_q + CNT_W'(load_use & ~taken & ~&stall_cnt_q);
    flush_cnt_d = flush_cnt_q + CNT_W'(taken & ~&flush_cnt_q);
  end
  ex_fwd_select #(.REG_AW(REG_AW), .ZR(ZR)) u_fwd_a (
    .en_i(id_valid), .src_i(id_rn),
    .ex_valid_i(ex_valid_q), .ex_reg_write_i(ex_reg_write_q), .ex_rd_i(ex_rd_q),
    .mem_valid_i(mem_valid_q), .mem_reg_write_i(mem_reg_write_q), .mem_rd_i(mem_rd_q),
    .sel_o(fwd_a_d)
  );
  ex_fwd_select #(.REG_AW(REG_AW), .ZR(ZR)) u_fwd_b (
    .en_i(id_valid & id_uses_rm), .src_i(id_rm),
    .ex_valid_i(ex_valid_q), .ex_reg_write_i(ex_reg_write_q), .ex_rd_i(ex_rd_q),
    .mem_valid_i(mem_valid_q), .mem_reg_write_i(mem_reg_write_q), .mem_rd_i(mem_rd_q),
    .sel_o(fwd_b_d)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q      <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_alu_op_q     <= ALUOP_LDST;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_cbz_q        <= 1'b0;
      ex_uncond_q     <= 1'b0;
      fwd_a_q         <= FWD_REG;
      fwd_b_q         <= FWD_REG;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      wb_valid_q      <= mem_valid_q;
      wb_rd_q         <= mem_rd_q;
      wb_reg_write_q  <= mem_reg_write_q;
      mem_valid_q     <= ex_valid_q;
      mem_rd_q        <= ex_rd_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_mem_read_q  <= ex_mem_read_q;
      ex_valid_q      <= ~bubble;
      ex_alu_src_q    <= ~bubble & id_alu_src;
      ex_alu_op_q     <= bubble ? ALUOP_LDST : id_alu_op;
      ex_rd_q         <= bubble ? '0 : id_rd;
      ex_reg_write_q  <= ~bubble & id_reg_write;
      ex_mem_read_q   <= ~bubble & id_mem_read;
      ex_mem_write_q  <= ~bubble & id_mem_write;
      ex_cbz_q        <= ~bubble & id_cbz;
      ex_uncond_q     <= ~bubble & id_uncond;
      fwd_a_q         <= bubble ? FWD_REG : fwd_a_d;
      fwd_b_q         <= bubble ? FWD_REG : fwd_b_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end
  // MEM/WB state and the store bit are tracked for observability only.
  assign unused_obs = ^{wb_valid_q, wb_rd_q, wb_reg_write_q, mem_mem_read_q, ex_mem_write_q};
  assign ex_valid   = ex_valid_q;
  assign ex_alu_src = ex_alu_src_q;
  assign ex_alu_op  = ex_alu_op_q;
  assign fwd_a      = fwd_a_q;
  assign fwd_b      = fwd_b_q;
  assign pc_write   = ~load_use | taken;
  assign ifid_write = ~load_use | taken;
  assign ifid_flush = taken;
  assign pc_src     = taken;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: random instruction stream against a stage-record model, scoreboard-checked.
module tb_ex_hazard_ctrl;
  localparam int CW = 10;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_uses_rm, id_reg_write, id_mem_read, id_mem_write, id_alu_src;
  logic id_cbz, id_uncond, ex_zero;
  logic [4:0] id_rn, id_rm, id_rd;
  logic [1:0] id_alu_op;
  logic ex_alu_src, ex_valid, pc_write, ifid_write, ifid_flush, pc_src;
  logic [1:0] ex_alu_op, fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;
  always #5 clk = ~clk;
  ex_hazard_ctrl #(.REG_AW(5), .ZERO_REG(31), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_uses_rm(id_uses_rm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_cbz(id_cbz), .id_uncond(id_uncond), .ex_zero(ex_zero),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_valid(ex_valid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .pc_src(pc_src), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  typedef struct {
    bit v; bit [4:0] rd; bit rw, mr, as; bit [1:0] op; bit cbz, unc; bit [1:0] fa, fb;
  } stage_t;
  typedef struct {
    bit pcw, ifw, fl, ps, exv, exas; bit [1:0] exop, fa, fb; int sc, fc;
  } exp_t;
  stage_t ex_m, mem_m;
  int stalls, flushes;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic bit [1:0] producer(bit [4:0] r);
    if (ex_m.v && ex_m.rw && ex_m.rd != 31 && ex_m.rd == r) return 2'b10;
    if (mem_m.v && mem_m.rw && mem_m.rd != 31 && mem_m.rd == r) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [4:0] pick();
    int k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction
  task automatic model_step();
    bit taken, lu;
    exp_t x;
    stage_t nx;
    if (reset) begin
      ex_m = '{default: 0};
      mem_m = '{default: 0};
      stalls = 0;
      flushes = 0;
    end
    taken = ex_m.v && (ex_m.unc || (ex_m.cbz && ex_zero));
    lu = id_valid && ex_m.v && ex_m.mr && ex_m.rd != 31 &&
         (id_rn == ex_m.rd || (id_uses_rm && id_rm == ex_m.rd));
    x.pcw = !lu || taken;
    x.ifw = !lu || taken;
    x.fl = taken;
    x.ps = taken;
    x.exv = ex_m.v;
    x.exas = ex_m.as;
    x.exop = ex_m.op;
    x.fa = ex_m.fa;
    x.fb = ex_m.fb;
    x.sc = stalls > CMAX ? CMAX : stalls;
    x.fc = flushes > CMAX ? CMAX : flushes;
    q.push_back(x);
    if (!reset) begin
      if (lu && !taken) stalls++;
      if (taken) flushes++;
      nx = '{default: 0};
      if (id_valid && !taken && !lu) begin
        nx.v = 1; nx.rd = id_rd; nx.rw = id_reg_write; nx.mr = id_mem_read; nx.as = id_alu_src;
        nx.op = id_alu_op; nx.cbz = id_cbz; nx.unc = id_uncond;
        nx.fa = producer(id_rn);
        nx.fb = id_uses_rm ? producer(id_rm) : 2'b00;
      end
      mem_m = ex_m;
      ex_m = nx;
    end
  endtask
  task automatic rand_id();
    id_valid = $urandom_range(0, 99) < 85;
    id_rn = pick();
    id_rm = pick();
    id_rd = pick();
    id_uses_rm = $urandom_range(0, 1) == 1;
    id_reg_write = $urandom_range(0, 3) != 0;
    id_mem_read = $urandom_range(0, 3) == 0;
    id_mem_write = $urandom_range(0, 7) == 0;
    id_alu_src = $urandom_range(0, 1) == 1;
    id_alu_op = 2'($urandom_range(0, 3));
    id_cbz = $urandom_range(0, 9) == 0;
    id_uncond = !id_cbz && $urandom_range(0, 14) == 0;
    ex_zero = $urandom_range(0, 1) == 1;
  endtask
  initial forever begin
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_write", int'(pc_write), int'(e.pcw));
      chk("ifid_write", int'(ifid_write), int'(e.ifw));
      chk("ifid_flush", int'(ifid_flush), int'(e.fl));
      chk("pc_src", int'(pc_src), int'(e.ps));
      chk("ex_valid", int'(ex_valid), int'(e.exv));
      chk("ex_alu_src", int'(ex_alu_src), int'(e.exas));
      chk("ex_alu_op", int'(ex_alu_op), int'(e.exop));
      chk("fwd_a", int'(fwd_a), int'(e.fa));
      chk("fwd_b", int'(fwd_b), int'(e.fb));
      chk("stall_cnt", int'(stall_cnt), e.sc);
      chk("flush_cnt", int'(flush_cnt), e.fc);
    end
  end
  initial begin
    reset = 1'b1;
    rand_id();
    id_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      model_step();
    end
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset = (i == 700);
      rand_id();
      model_step();
    end
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      reset = 1'b0;
      id_valid = 1'b1; id_rn = 5'd1; id_rd = 5'd1; id_rm = 5'd0; id_uses_rm = 1'b0;
      id_mem_read = 1'b1; id_reg_write = 1'b1; id_mem_write = 1'b0; id_alu_src = 1'b1;
      id_alu_op = 2'b00; id_cbz = 1'b0; id_uncond = 1'b0; ex_zero = 1'b0;
      model_step();
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rand_id();
      model_step();
    end
    repeat (2) @(negedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
